// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter slice.
//  NREQ        number of requesters sharing the port
//  SELW        width of the grantee index / mux select
//  arb_state_e arbiter FSM states
//  onehot()    index -> one-hot requester vector
package arb_pkg;

   localparam int NREQ = 4;
   localparam int SELW = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] i);
      logic [NREQ-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// Handshake: a requester raises req[i] and holds addr/wdata/we until it
// sees done[i] (one-cycle pulse). On the memory side mem_valid stays high
// for the whole access; the access completes in the cycle mem_ready=1.
//  master : arbiter view (drives gnt/done/rdata/sel/mem_*/timeout_err)
//  slave  : environment view (drives req/addr_i/wdata_i/we_i/mem_ready/mem_rdata)
interface mem_port_arbiter_if;
   import arb_pkg::*;

   logic [NREQ-1:0]    req;
   logic [32*NREQ-1:0] addr_i;
   logic [32*NREQ-1:0] wdata_i;
   logic [NREQ-1:0]    we_i;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [31:0]        rdata;
   logic [SELW-1:0]    sel;
   logic               mem_valid;
   logic [31:0]        mem_addr;
   logic [31:0]        mem_wdata;
   logic               mem_we;
   logic               mem_ready;
   logic [31:0]        mem_rdata;
   logic               timeout_err;

   modport master (
      input  req, addr_i, wdata_i, we_i, mem_ready, mem_rdata,
      output gnt, done, rdata, sel, mem_valid, mem_addr, mem_wdata, mem_we,
             timeout_err
   );

   modport slave (
      output req, addr_i, wdata_i, we_i, mem_ready, mem_rdata,
      input  gnt, done, rdata, sel, mem_valid, mem_addr, mem_wdata, mem_we,
             timeout_err
   );

endinterface

// File: rtl/Fourmux32.sv
// Four-input 32-bit multiplexer used for address and write-data steering.
//  d0..d3 in  data inputs
//  sel    in  select
//  y      out selected input
module Fourmux32 (
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   input  logic [1:0]  sel,
   output logic [31:0] y
);

   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
//  elig  in  eligible requesters
//  ptr   in  index holding highest priority
//  any   out at least one eligible requester
//  idx   out first eligible index scanning ptr, ptr+1, ... (mod 4)
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] elig,
   input  logic [SELW-1:0] ptr,
   output logic            any,
   output logic [SELW-1:0] idx
);

   // Scan from the farthest offset down so the nearest eligible one wins.
   always_comb begin
      any = 1'b0;
      idx = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (elig[ptr + SELW'(k)]) begin
            any = 1'b1;
            idx = ptr + SELW'(k);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port among 4 requesters.
// Each transaction runs IDLE -> BUSY -> IDLE; the grantee index drives the
// address / write-data muxes.
//  clk, rst_n  clock (rising edge), asynchronous active-low reset
//  bus         mem_port_arbiter_if.master (requester and memory signals)
//  dbg_state   current FSM state
// Parameters: TIMEOUT (BUSY cycle limit, >=2), RESET_PTR (priority after reset).
// Build option: define ARB_TIMEOUT_EN to abort accesses that see no
// mem_ready for TIMEOUT BUSY cycles; otherwise BUSY waits indefinitely and
// timeout_err is constant 0.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT   = 16,
   parameter int RESET_PTR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.master  bus,
   output arb_state_e          dbg_state
);

   arb_state_e      state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            pick_any;
   logic [SELW-1:0] pick_idx;
   logic            abort;
   logic            busy;

   assign busy = (state_q == ARB_BUSY);

   // Masking by done keeps a requester from being re-granted in the same
   // cycle its completion pulse is visible.
   rr_pick4 u_pick (
      .elig (bus.req & ~done_q),
      .ptr  (ptr_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic          terr_q;

   assign abort = busy && !bus.mem_ready && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= busy ? cnt_q + 1'b1 : '0;
         terr_q <= abort;
      end
   end

   assign bus.timeout_err = terr_q;
`else
   localparam int unused_timeout = TIMEOUT;

   assign abort           = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         sel_q   <= SELW'(RESET_PTR);
         ptr_q   <= SELW'(RESET_PTR);
         done_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      done_d  = '0;
      rdata_d = rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BUSY;
               sel_d   = pick_idx;
            end
         end
         ARB_BUSY: begin
            if (bus.mem_ready) begin
               state_d = ARB_IDLE;
               done_d  = onehot(sel_q);
               rdata_d = bus.mem_rdata;
               ptr_d   = sel_q + 1'b1;
            end else if (abort) begin
               state_d = ARB_IDLE;
               done_d  = onehot(sel_q);
               rdata_d = '0;
               ptr_d   = sel_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   Fourmux32 u_addr_mux (
      .d0  (bus.addr_i[31:0]),
      .d1  (bus.addr_i[63:32]),
      .d2  (bus.addr_i[95:64]),
      .d3  (bus.addr_i[127:96]),
      .sel (sel_q),
      .y   (bus.mem_addr)
   );

   Fourmux32 u_wdata_mux (
      .d0  (bus.wdata_i[31:0]),
      .d1  (bus.wdata_i[63:32]),
      .d2  (bus.wdata_i[95:64]),
      .d3  (bus.wdata_i[127:96]),
      .sel (sel_q),
      .y   (bus.mem_wdata)
   );

   assign bus.gnt       = busy ? onehot(sel_q) : '0;
   assign bus.mem_valid = busy;
   assign bus.mem_we    = bus.we_i[sel_q] & busy;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.sel       = sel_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RESET_PTR = 0, TIMEOUT = 16).
// Define ARB_TIMEOUT_EN for both bench and RTL to exercise the abort path.
module tb_mem_port_arbiter;
   import arb_pkg::*;

   logic       clk;
   logic       rst_n;
   arb_state_e dbg_state;
   int         n_checks;
   int         n_pass;

   mem_port_arbiter_if bus_if ();

   mem_port_arbiter #(.TIMEOUT(16), .RESET_PTR(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.req       = '0;
      bus_if.we_i      = '0;
      bus_if.mem_ready = 1'b0;
   endtask

   // scoreboard comparison
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      bus_if.mem_rdata = 32'h0;
      bus_if.addr_i    = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
      bus_if.wdata_i   = {32'hD3D3_D3D3, 32'h1234_5678, 32'hB1B1_B1B1, 32'hA0A0_A0A0};

      // reset state
      #4;
      check("rst_gnt", 32'(bus_if.gnt), 32'h0);
      check("rst_done", 32'(bus_if.done), 32'h0);
      check("rst_rdata", bus_if.rdata, 32'h0);
      check("rst_sel", 32'(bus_if.sel), 32'h0);
      check("rst_valid", 32'(bus_if.mem_valid), 32'h0);
      check("rst_terr", 32'(bus_if.timeout_err), 32'h0);
      #8 rst_n = 1'b1;

      // 1: single read from requester 1
      bus_if.req = 4'b0010;
      step();
      check("t1_gnt", 32'(bus_if.gnt), 32'h2);
      check("t1_sel", 32'(bus_if.sel), 32'h1);
      check("t1_valid", 32'(bus_if.mem_valid), 32'h1);
      check("t1_addr", bus_if.mem_addr, 32'h0000_0100);
      check("t1_we", 32'(bus_if.mem_we), 32'h0);
      check("t1_state", 32'(dbg_state), 32'(ARB_BUSY));
      step();
      check("t1_gnt_hold", 32'(bus_if.gnt), 32'h2);
      check("t1_done_early", 32'(bus_if.done), 32'h0);
      bus_if.mem_ready = 1'b1;
      bus_if.mem_rdata = 32'hDEAD_BEEF;
      step();
      check("t1_done", 32'(bus_if.done), 32'h2);
      check("t1_rdata", bus_if.rdata, 32'hDEAD_BEEF);
      check("t1_gnt_off", 32'(bus_if.gnt), 32'h0);
      check("t1_valid_off", 32'(bus_if.mem_valid), 32'h0);
      idle_inputs();
      step();
      check("t1_done_pulse", 32'(bus_if.done), 32'h0);
      check("t1_sel_hold", 32'(bus_if.sel), 32'h1);

      // reset to bring ptr back to 0
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;

      // 2: contention, all four requesting, memory always ready
      bus_if.req       = 4'b1111;
      bus_if.mem_ready = 1'b1;
      bus_if.mem_rdata = 32'h1111_0000;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("t2_gnt%0d", i), 32'(bus_if.gnt), 32'(1) << order[i]);
         check($sformatf("t2_sel%0d", i), 32'(bus_if.sel), 32'(order[i]));
         step();
         check($sformatf("t2_done%0d", i), 32'(bus_if.done), 32'(1) << order[i]);
         check($sformatf("t2_gntoff%0d", i), 32'(bus_if.gnt), 32'h0);
      end
      idle_inputs();
      step();

      // 3: write from requester 2
      bus_if.req  = 4'b0100;
      bus_if.we_i = 4'b0100;
      step();
      check("t3_gnt", 32'(bus_if.gnt), 32'h4);
      check("t3_sel", 32'(bus_if.sel), 32'h2);
      check("t3_we", 32'(bus_if.mem_we), 32'h1);
      check("t3_wdata", bus_if.mem_wdata, 32'h1234_5678);
      check("t3_addr", bus_if.mem_addr, 32'h0000_0200);
      bus_if.mem_ready = 1'b1;
      bus_if.mem_rdata = 32'hCAFE_0002;
      step();
      check("t3_done", 32'(bus_if.done), 32'h4);
      check("t3_we_off", 32'(bus_if.mem_we), 32'h0);
      idle_inputs();
      step();

      // 4: re-grant mask, only requester 0 held
      bus_if.req       = 4'b0001;
      bus_if.mem_ready = 1'b1;
      bus_if.mem_rdata = 32'h0BAD_F00D;
      step();
      check("t4_gnt", 32'(bus_if.gnt), 32'h1);
      step();
      check("t4_done", 32'(bus_if.done), 32'h1);
      check("t4_no_gnt_done", 32'(bus_if.gnt), 32'h0);
      step();
      check("t4_idle_gnt", 32'(bus_if.gnt), 32'h0);
      check("t4_idle_state", 32'(dbg_state), 32'(ARB_IDLE));
      step();
      check("t4_regnt", 32'(bus_if.gnt), 32'h1);
      step();
      check("t4_done2", 32'(bus_if.done), 32'h1);
      idle_inputs();
      step();

      // mem_ready while idle is ignored
      bus_if.mem_ready = 1'b1;
      bus_if.mem_rdata = 32'h5555_5555;
      step();
      check("idle_rdy_done", 32'(bus_if.done), 32'h0);
      check("idle_rdy_rdata", bus_if.rdata, 32'h0BAD_F00D);
      check("idle_rdy_valid", 32'(bus_if.mem_valid), 32'h0);
      idle_inputs();

`ifdef ARB_TIMEOUT_EN
      // 6: memory never ready -> abort after 16 BUSY cycles
      bus_if.req = 4'b0110;
      step();
      check("t6_gnt", 32'(bus_if.gnt), 32'h2);
      repeat (15) step();
      check("t6_gnt_c16", 32'(bus_if.gnt), 32'h2);
      check("t6_terr_early", 32'(bus_if.timeout_err), 32'h0);
      step();
      check("t6_done", 32'(bus_if.done), 32'h2);
      check("t6_terr", 32'(bus_if.timeout_err), 32'h1);
      check("t6_rdata", bus_if.rdata, 32'h0);
      step();
      check("t6_next_gnt", 32'(bus_if.gnt), 32'h4);
      check("t6_terr_pulse", 32'(bus_if.timeout_err), 32'h0);
      bus_if.mem_ready = 1'b1;
      step();
      check("t6_next_done", 32'(bus_if.done), 32'h4);
      idle_inputs();
      step();
`else
      check("terr_tied", 32'(bus_if.timeout_err), 32'h0);
`endif

      // 5: reset while requester 3 is in BUSY
      bus_if.req = 4'b1000;
      step();
      check("t5_gnt", 32'(bus_if.gnt), 32'h8);
      check("t5_sel", 32'(bus_if.sel), 32'h3);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_gnt", 32'(bus_if.gnt), 32'h0);
      check("t5_rst_valid", 32'(bus_if.mem_valid), 32'h0);
      check("t5_rst_done", 32'(bus_if.done), 32'h0);
      check("t5_rst_sel", 32'(bus_if.sel), 32'h0);
      check("t5_rst_rdata", bus_if.rdata, 32'h0);
      check("t5_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      bus_if.req = 4'b0000;
      step();
      rst_n = 1'b1;
      step();
      check("t5_post_done", 32'(bus_if.done), 32'h0);
      check("t5_post_sel", 32'(bus_if.sel), 32'h0);
      check("t5_post_gnt", 32'(bus_if.gnt), 32'h0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
